// File: rtl/modport_source_driver.sv
// modport_source_driver: drives an interface source-modport field from value_i, with a latched override and a sink-side loopback check
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   value_i             normal-path value (optionally inverted)
//   set_valid_i         strobe that loads set_data_i[WIDTH-1:0] as the override value
//   set_data_i          32-bit override word; zero-extended when WIDTH > 32
//   release_i           strobe that leaves override mode (set_valid_i takes priority)
//   sink_i              value read back through the sink modport
//   intf_o              registered source-modport field
//   override_active_o   high while override mode is active
//   mismatch_o          sink_i differed from intf_o on the previous cycle
module modport_source_driver #(
    parameter int               WIDTH     = 1,
    parameter bit               INVERT    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value_i,
    input  logic             set_valid_i,
    input  logic [31:0]      set_data_i,
    input  logic             release_i,
    input  logic [WIDTH-1:0] sink_i,
    output logic [WIDTH-1:0] intf_o,
    output logic             override_active_o,
    output logic             mismatch_o
);
    logic [WIDTH-1:0] intf_q, intf_d, ovr_q, ovr_d, nxt, set_w;
    logic             active_q, active_d, mismatch_q, mismatch_d;
    // The size cast truncates for narrow fields and zero-extends for WIDTH > 32.
    assign set_w = WIDTH'(set_data_i);
    assign nxt   = INVERT ? ~value_i : value_i;
    always_comb begin
        ovr_d      = set_valid_i ? set_w : ovr_q;
        active_d   = set_valid_i | (active_q & ~release_i);
        intf_d     = set_valid_i ? set_w : (active_d ? ovr_q : nxt);
        mismatch_d = sink_i != intf_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intf_q     <= RESET_VAL;
            ovr_q      <= RESET_VAL;
            active_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            intf_q     <= intf_d;
            ovr_q      <= ovr_d;
            active_q   <= active_d;
            mismatch_q <= mismatch_d;
        end
    end
    assign intf_o            = intf_q;
    assign override_active_o = active_q;
    assign mismatch_o        = mismatch_q;
endmodule

// File: tb/tb_modport_source_driver.sv
// tb_modport_source_driver: table-driven scoreboard bench for modport_source_driver
module tb_modport_source_driver;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [5:0]  val = '0, intf, sink;
    logic        sv = 1'b0, rel = 1'b0, flip = 1'b0, act, mis;
    logic [31:0] sd = '0;
    logic        inv_intf, inv_act, inv_mis;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [5:0]  val;
        logic        sv;
        logic [31:0] sd;
        logic        rel;
        logic        flip;
        logic [5:0]  e_intf;
        logic        e_act;
        logic        e_mis;
    } vec_t;
    typedef struct {
        logic [5:0] intf;
        logic       act;
        logic       mis;
        logic       inv;
    } exp_t;

    vec_t vecs[14];
    exp_t q[$];

    always #5 clk = ~clk;
    assign sink = intf ^ {6{flip}};

    modport_source_driver #(.WIDTH(6), .INVERT(1'b0), .RESET_VAL(6'h15)) u_dut (
        .clk(clk), .rst_n(rst_n), .value_i(val), .set_valid_i(sv), .set_data_i(sd),
        .release_i(rel), .sink_i(sink), .intf_o(intf), .override_active_o(act), .mismatch_o(mis)
    );

    modport_source_driver #(.WIDTH(1), .INVERT(1'b1), .RESET_VAL(1'b0)) u_inv (
        .clk(clk), .rst_n(rst_n), .value_i(val[0]), .set_valid_i(1'b0), .set_data_i(32'h0),
        .release_i(1'b0), .sink_i(inv_intf), .intf_o(inv_intf), .override_active_o(inv_act),
        .mismatch_o(inv_mis)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        val = v.val; sv = v.sv; sd = v.sd; rel = v.rel; flip = v.flip;
        q.push_back('{v.e_intf, v.e_act, v.e_mis, ~v.val[0]});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("intf", 64'(intf), 64'(e.intf));
        chk("override_active", 64'(act), 64'(e.act));
        chk("mismatch", 64'(mis), 64'(e.mis));
        chk("inv_intf", 64'(inv_intf), 64'(e.inv));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //              val    sv    sd        rel   flip  intf   act   mis
        vecs[0]  = '{6'h01, 1'b0, 32'h00, 1'b0, 1'b0, 6'h01, 1'b0, 1'b0};
        vecs[1]  = '{6'h2A, 1'b0, 32'h00, 1'b0, 1'b0, 6'h2A, 1'b0, 1'b0};
        vecs[2]  = '{6'h00, 1'b0, 32'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0};
        vecs[3]  = '{6'h11, 1'b1, 32'h40, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0};
        vecs[4]  = '{6'h3F, 1'b0, 32'h00, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0};
        vecs[5]  = '{6'h05, 1'b1, 32'h7F, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0};
        vecs[6]  = '{6'h12, 1'b0, 32'h00, 1'b1, 1'b0, 6'h12, 1'b0, 1'b0};
        vecs[7]  = '{6'h13, 1'b1, 32'h21, 1'b1, 1'b0, 6'h21, 1'b1, 1'b0};
        vecs[8]  = '{6'h14, 1'b0, 32'h00, 1'b0, 1'b1, 6'h21, 1'b1, 1'b1};
        vecs[9]  = '{6'h14, 1'b0, 32'h00, 1'b0, 1'b0, 6'h21, 1'b1, 1'b0};
        vecs[10] = '{6'h07, 1'b0, 32'h00, 1'b1, 1'b0, 6'h07, 1'b0, 1'b0};
        vecs[11] = '{6'h08, 1'b0, 32'h00, 1'b0, 1'b1, 6'h08, 1'b0, 1'b1};
        vecs[12] = '{6'h09, 1'b0, 32'h00, 1'b0, 1'b0, 6'h09, 1'b0, 1'b0};
        vecs[13] = '{6'h0A, 1'b0, 32'h00, 1'b1, 1'b0, 6'h0A, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_intf", 64'(intf), 64'h15);
        chk("reset_active", 64'(act), 64'h0);
        chk("reset_mismatch", 64'(mis), 64'h0);
        chk("reset_inv_intf", 64'(inv_intf), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) step(vecs[i]);

        step('{6'h00, 1'b1, 32'h3F, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b0});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_intf", 64'(intf), 64'h15);
        chk("async_reset_active", 64'(act), 64'h0);
        chk("async_reset_mismatch", 64'(mis), 64'h0);
        @(posedge clk);
        #1;
        chk("reset_held_intf", 64'(intf), 64'h15);
        chk("reset_held_active", 64'(act), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; sv = 1'b0; rel = 1'b0; flip = 1'b0; val = 6'h00; sd = '0;
        @(posedge clk);
        #1;
        chk("post_reset_intf", 64'(intf), 64'h00);
        chk("post_reset_active", 64'(act), 64'h0);
        step('{6'h0C, 1'b0, 32'h00, 1'b0, 1'b0, 6'h0C, 1'b0, 1'b0});
        step('{6'h33, 1'b0, 32'h00, 1'b0, 1'b0, 6'h33, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/modport_source_driver.md
Name: modport_source_driver

Overview:
- Drives the output field of an interface's source modport from a local value input.
- Provides a software-style override path: a 32-bit set word whose low bits force the interface value until released.
- Sits between producer logic and an interface-array element; downstream sink-modport readers see the driven value.
- Includes an optional inversion stage and a loopback consistency check against the sink-side view.

Parameters:
- WIDTH, 1, width of the interface field driven through the source modport (1..64).
- INVERT, 0, when 1 the normal path drives the bitwise inverse of value_i.
- RESET_VAL, 0, value of intf_o and the override register during reset; WIDTH bits.

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value_i  input  WIDTH  normal-path value driven onto the interface.
- set_valid_i  input  1  one-cycle strobe that loads set_data_i into the override register.
- set_data_i  input  32  override word; only bits [WIDTH-1:0] are used, zero-extended if WIDTH>32.
- release_i  input  1  one-cycle strobe that clears override mode.
- sink_i  input  WIDTH  value read back through the sink modport of the same interface element.
- intf_o  output  WIDTH  source-modport field (logic_in_intf equivalent).
- override_active_o  output  1  high while override mode is active.
- mismatch_o  output  1  registered flag: sink_i differed from intf_o in the previous cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - intf_o = RESET_VAL, override register = RESET_VAL.
  - override_active_o = 0, mismatch_o = 0.
  - All held while rst_n is low.
- Normal path:
  - nxt = INVERT ? ~value_i : value_i.
  - intf_o <= nxt on each rising edge.
  - Latency is 1 cycle from value_i to intf_o.
- Override load:
  - set_valid_i=1 at an edge loads ovr <= set_data_i[WIDTH-1:0] and sets override_active <= 1.
  - intf_o <= set_data_i[WIDTH-1:0] on the same edge.
  - Latency is 1 cycle. INVERT does not apply to override data.
- Override hold: while override_active=1, intf_o <= ovr; value_i is ignored.
- Release:
  - release_i=1 (without set_valid_i) sets override_active <= 0.
  - intf_o <= nxt on the same edge, so the normal value appears 1 cycle after release.
- Simultaneous events:
  - set_valid_i and release_i together: set wins; override loads and stays active.
  - Repeated set_valid_i while already active reloads ovr with the new value.
- Mismatch check:
  - mismatch_o <= (sink_i != intf_o) every cycle; not sticky.
  - Cleared by reset; the check is active in both normal and override modes.
- Reset mid-override: override is dropped immediately and intf_o returns to RESET_VAL.
- Post-reset mode: normal mode.
- Width rules:
  - set_data_i bits above WIDTH-1 are ignored.
  - For WIDTH>32, upper bits of ovr are 0.
- No combinational path from any input to any output.

Test Plan:
- Normal pass-through (WIDTH=1, INVERT=0): reset, then value_i=1 -> intf_o=1 one cycle later; value_i=0 -> intf_o=0 next cycle; override_active_o=0 throughout.
- Inverted mode (INVERT=1): value_i=0 -> intf_o=1; value_i=1 -> intf_o=0, each with 1-cycle latency.
- Override (WIDTH=1):
  - set_data_i=0x2 with set_valid_i -> intf_o=0 and override_active_o=1 next cycle.
  - Toggling value_i has no effect.
  - set_data_i=0x3 -> intf_o=1.
- Release and priority:
  - release_i -> intf_o follows value_i next cycle and override_active_o=0.
  - set_valid_i plus release_i in the same cycle with data 0x1 -> override stays active with intf_o=1.
- Reset mid-override (WIDTH=6, RESET_VAL=6'h15):
  - Set 0x3F, then assert rst_n=0 between edges -> intf_o=6'h15 immediately and override_active_o=0.
  - After rst_n returns high, the normal path resumes.
- Loopback check: sink_i tied to intf_o -> mismatch_o=0; force sink_i to differ for one cycle -> mismatch_o=1 for exactly one cycle, then back to 0.
